// File: rtl/mem_arbiter_if.sv
// Request/response bus of the data-memory arbiter: pipeline port, loader
// port and the synchronous memory port. The slave modport is the arbiter,
// the master modport is the requesters plus the memory it fronts.
interface mem_arbiter_if #(
  parameter int MEM_AW = 8
);
  logic              p_req;
  logic              p_we;
  logic [63:0]       p_addr;
  logic [63:0]       p_wdata;
  logic              l_req;
  logic              l_we;
  logic [63:0]       l_addr;
  logic [63:0]       l_wdata;
  logic              p_ack;
  logic              l_ack;
  logic [63:0]       p_rdata;
  logic [63:0]       l_rdata;
  logic              p_err;
  logic              l_err;
  logic              p_stall;
  logic [2:0]        m_stat_adr;
  logic              mem_en;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [63:0]       mem_wdata;
  logic [63:0]       mem_rdata;

  modport slave (
    input  p_req, p_we, p_addr, p_wdata,
    input  l_req, l_we, l_addr, l_wdata,
    input  mem_rdata,
    output p_ack, l_ack, p_rdata, l_rdata, p_err, l_err,
    output p_stall, m_stat_adr,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output p_req, p_we, p_addr, p_wdata,
    output l_req, l_we, l_addr, l_wdata,
    output mem_rdata,
    input  p_ack, l_ack, p_rdata, l_rdata, p_err, l_err,
    input  p_stall, m_stat_adr,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous data memory.
// One access per two cycles: the grant cycle drives the memory port, the
// following BUSY cycle returns ack/rdata/err to the grantee. Ties are broken
// round-robin; out-of-range addresses are flagged and never reach memory.
module mem_arbiter #(
  parameter int MEM_DEPTH = 256,
  parameter int MEM_AW    = 8
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic { IDLE, BUSY } state_t;
  typedef enum logic { PIPE, LOADER } who_t;

  state_t      state, state_nxt;
  who_t        rr_last;
  who_t        owner_q;
  logic        we_q;
  logic        err_q;

  logic        gnt;
  who_t        gnt_who;
  logic        sel_we;
  logic [63:0] sel_addr;
  logic [63:0] sel_wdata;
  logic        addr_err;
  logic        ack_live;
  logic [63:0] rsp_data;

  // Arbitration, memory-port drive and response outputs for the current cycle
  always_comb begin
    state_nxt      = state;
    gnt            = 1'b0;
    gnt_who        = PIPE;
    sel_we         = 1'b0;
    sel_addr       = '0;
    sel_wdata      = '0;
    addr_err       = 1'b0;
    ack_live       = 1'b0;
    rsp_data       = '0;
    bus.mem_en     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.p_ack      = 1'b0;
    bus.l_ack      = 1'b0;
    bus.p_rdata    = '0;
    bus.l_rdata    = '0;
    bus.p_err      = 1'b0;
    bus.l_err      = 1'b0;

    case (state)
      IDLE: begin
        // Grants are suppressed under reset so nothing reaches memory then
        if (!rst && (bus.p_req || bus.l_req)) begin
          gnt       = 1'b1;
          gnt_who   = (bus.l_req && (!bus.p_req || rr_last == PIPE)) ? LOADER : PIPE;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        state_nxt = IDLE;
        // Reset landing on the BUSY cycle swallows the ack pulse
        ack_live  = !rst;
      end
      default: state_nxt = IDLE;
    endcase

    if (gnt) begin
      sel_we    = (gnt_who == LOADER) ? bus.l_we    : bus.p_we;
      sel_addr  = (gnt_who == LOADER) ? bus.l_addr  : bus.p_addr;
      sel_wdata = (gnt_who == LOADER) ? bus.l_wdata : bus.p_wdata;
      addr_err  = (sel_addr >= 64'(MEM_DEPTH));
      if (!addr_err) begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = sel_we;
        bus.mem_addr  = sel_addr[MEM_AW-1:0];
        bus.mem_wdata = sel_wdata;
      end
    end

    rsp_data = (we_q || err_q) ? '0 : bus.mem_rdata;
    if (ack_live) begin
      if (owner_q == LOADER) begin
        bus.l_ack   = 1'b1;
        bus.l_rdata = rsp_data;
        bus.l_err   = err_q;
      end else begin
        bus.p_ack   = 1'b1;
        bus.p_rdata = rsp_data;
        bus.p_err   = err_q;
      end
    end

    bus.p_stall    = bus.p_req && !bus.p_ack;
    bus.m_stat_adr = (bus.p_ack && bus.p_err) ? 3'd3 : 3'd0;
  end

  // State register plus the per-access context latched at grant
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rr_last <= LOADER;
      owner_q <= PIPE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (gnt) begin
        owner_q <= gnt_who;
        we_q    <= sel_we;
        err_q   <= addr_err;
        if (bus.p_req && bus.l_req) begin
          rr_last <= gnt_who;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed timing scenarios plus randomized traffic
// from both requesters. Issued transactions are queued per requester; a
// negedge monitor pops on every ack and checks against a sparse reference
// memory updated in completion order.
module tb_mem_arbiter;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.MEM_AW(AW)) bus ();

  mem_arbiter #(.MEM_DEPTH(DEPTH), .MEM_AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Synchronous memory behind the arbiter
  logic [63:0] ram [DEPTH];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } txn_t;

  txn_t        pq[$];
  txn_t        lq[$];
  logic [63:0] ref_mem [logic [63:0]];
  int          total = 0;
  int          bad   = 0;
  bit          mon_on = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_read(input logic [63:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 64'd0;
  endfunction

  task automatic score(input string who, input txn_t t, input logic [63:0] rd, input logic er);
    logic [63:0] exp_rd;
    logic        exp_er;
    exp_er = (t.addr >= 64'(DEPTH));
    exp_rd = (t.we || exp_er) ? 64'd0 : ref_read(t.addr);
    if (t.we && !exp_er) ref_mem[t.addr] = t.wdata;
    chk({who, "_rdata"}, rd, exp_rd);
    chk({who, "_err"}, 64'(er), 64'(exp_er));
  endtask

  // Monitor: protocol invariants every cycle, scoreboard pop on each ack
  always @(negedge clk) begin
    if (mon_on && !rst) begin
      chk("p_stall", 64'(bus.p_stall), 64'(bus.p_req && !bus.p_ack));
      chk("m_stat_adr", 64'(bus.m_stat_adr), (bus.p_ack && bus.p_err) ? 64'd3 : 64'd0);
      chk("dual_ack", 64'(bus.p_ack && bus.l_ack), 64'd0);
      if (bus.p_ack) begin
        if (pq.size() == 0) chk("p_ack_unrequested", 64'(bus.p_ack), 64'd0);
        else score("p", pq.pop_front(), bus.p_rdata, bus.p_err);
      end else begin
        chk("p_idle_rdata", bus.p_rdata, 64'd0);
        chk("p_idle_err", 64'(bus.p_err), 64'd0);
      end
      if (bus.l_ack) begin
        if (lq.size() == 0) chk("l_ack_unrequested", 64'(bus.l_ack), 64'd0);
        else score("l", lq.pop_front(), bus.l_rdata, bus.l_err);
      end else begin
        chk("l_idle_rdata", bus.l_rdata, 64'd0);
        chk("l_idle_err", 64'(bus.l_err), 64'd0);
      end
    end
  end

  // One complete access: raise req, wait (bounded) for ack, drop req.
  // lat is the cycle index of the ack relative to the issue cycle.
  task automatic access(input bit is_l, input logic we, input logic [63:0] addr,
                        input logic [63:0] wdata, output int lat, output logic en0,
                        output logic we0, output logic [63:0] rd, output logic er,
                        output logic [2:0] stat, output bit stall_ok);
    txn_t t;
    logic a;
    t = '{we, addr, wdata};
    @(posedge clk); #1;
    if (is_l) begin
      bus.l_req = 1'b1; bus.l_we = we; bus.l_addr = addr; bus.l_wdata = wdata;
      lq.push_back(t);
    end else begin
      bus.p_req = 1'b1; bus.p_we = we; bus.p_addr = addr; bus.p_wdata = wdata;
      pq.push_back(t);
    end
    lat = -1; stall_ok = 1'b1; en0 = 1'b0; we0 = 1'b0; rd = '0; er = 1'b0; stat = '0;
    a = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      a = is_l ? bus.l_ack : bus.p_ack;
      if (i == 0) begin
        en0 = bus.mem_en;
        we0 = bus.mem_we;
      end
      if (a) begin
        lat  = i;
        rd   = is_l ? bus.l_rdata : bus.p_rdata;
        er   = is_l ? bus.l_err : bus.p_err;
        stat = bus.m_stat_adr;
        if (!is_l && bus.p_stall) stall_ok = 1'b0;
        break;
      end
      if (!is_l && !bus.p_stall) stall_ok = 1'b0;
    end
    if (lat < 0) chk(is_l ? "l_ack_timeout" : "p_ack_timeout", 64'(a), 64'd1);
    @(posedge clk); #1;
    if (is_l) bus.l_req = 1'b0;
    else      bus.p_req = 1'b0;
  endtask

  function automatic logic [63:0] rand_addr();
    if ($urandom_range(0, 9) == 0) begin
      if ($urandom_range(0, 1) == 1) return 64'(DEPTH) + 64'($urandom_range(0, 7));
      else return {1'b1, 31'($urandom), 32'($urandom)};
    end
    return 64'($urandom_range(0, 15));
  endfunction

  int          lat_p, lat_l;
  logic        en_p, en_l, we_p, we_l, er_p, er_l;
  logic [63:0] rd_p, rd_l;
  logic [2:0]  st_p, st_l;
  bit          so_p, so_l;
  logic [63:0] wr_data;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    bus.p_req = 1'b0; bus.p_we = 1'b0; bus.p_addr = '0; bus.p_wdata = '0;
    bus.l_req = 1'b0; bus.l_we = 1'b0; bus.l_addr = '0; bus.l_wdata = '0;
    for (int i = 0; i < DEPTH; i++) ram[i] = '0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Cycle after reset: all outputs quiet
    @(negedge clk);
    chk("rst_p_ack", 64'(bus.p_ack), 64'd0);
    chk("rst_l_ack", 64'(bus.l_ack), 64'd0);
    chk("rst_p_err", 64'(bus.p_err), 64'd0);
    chk("rst_l_err", 64'(bus.l_err), 64'd0);
    chk("rst_p_rdata", bus.p_rdata, 64'd0);
    chk("rst_l_rdata", bus.l_rdata, 64'd0);
    chk("rst_mem_en", 64'(bus.mem_en), 64'd0);
    chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
    chk("rst_m_stat_adr", 64'(bus.m_stat_adr), 64'd0);
    mon_on = 1'b1;

    // Both held from reset: pipeline wins first tie, then strict alternation
    pq.push_back('{1'b0, 64'h40, 64'd0}); pq.push_back('{1'b0, 64'h40, 64'd0});
    lq.push_back('{1'b0, 64'h41, 64'd0}); lq.push_back('{1'b0, 64'h41, 64'd0});
    @(posedge clk); #1;
    bus.p_req = 1'b1; bus.p_we = 1'b0; bus.p_addr = 64'h40;
    bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 64'h41;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("rr_p_ack_c%0d", i), 64'(bus.p_ack), 64'(i == 1 || i == 5));
      chk($sformatf("rr_l_ack_c%0d", i), 64'(bus.l_ack), 64'(i == 3 || i == 7));
    end
    @(posedge clk); #1;
    bus.p_req = 1'b0; bus.l_req = 1'b0;

    // Pipeline write then read-back of the same word
    access(1'b0, 1'b1, 64'h10, 64'hDEAD, lat_p, en_p, we_p, rd_p, er_p, st_p, so_p);
    chk("wr_mem_en_c0", 64'(en_p), 64'd1);
    chk("wr_mem_we_c0", 64'(we_p), 64'd1);
    chk("wr_ack_cycle", 64'(lat_p), 64'd1);
    access(1'b0, 1'b0, 64'h10, 64'd0, lat_p, en_p, we_p, rd_p, er_p, st_p, so_p);
    chk("rd_mem_en_c0", 64'(en_p), 64'd1);
    chk("rd_mem_we_c0", 64'(we_p), 64'd0);
    chk("rd_ack_cycle", 64'(lat_p), 64'd1);
    chk("rd_data", rd_p, 64'hDEAD);

    // First out-of-range address
    access(1'b0, 1'b0, 64'h100, 64'd0, lat_p, en_p, we_p, rd_p, er_p, st_p, so_p);
    chk("oob_mem_en", 64'(en_p), 64'd0);
    chk("oob_ack_cycle", 64'(lat_p), 64'd1);
    chk("oob_err", 64'(er_p), 64'd1);
    chk("oob_stat", 64'(st_p), 64'd3);
    chk("oob_rdata", rd_p, 64'd0);

    // Pipeline arrives while the loader is being served: stalls until its ack
    fork
      access(1'b1, 1'b0, 64'h11, 64'd0, lat_l, en_l, we_l, rd_l, er_l, st_l, so_l);
      begin
        @(posedge clk);
        access(1'b0, 1'b0, 64'h12, 64'd0, lat_p, en_p, we_p, rd_p, er_p, st_p, so_p);
      end
    join
    chk("stall_l_ack_cycle", 64'(lat_l), 64'd1);
    chk("stall_p_ack_cycle", 64'(lat_p), 64'd2);
    chk("stall_profile", 64'(so_p), 64'd1);

    // Reset during the BUSY cycle of a loader write
    wr_data = 64'hC0FFEE_0000_1234;
    @(posedge clk); #1;
    bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 64'h20; bus.l_wdata = wr_data;
    lq.push_back('{1'b1, 64'h20, wr_data});
    @(negedge clk);
    chk("abort_mem_en", 64'(bus.mem_en), 64'd1);
    chk("abort_mem_we", 64'(bus.mem_we), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1; bus.l_req = 1'b0;
    @(negedge clk);
    chk("abort_no_l_ack", 64'(bus.l_ack), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    void'(lq.pop_front());
    ref_mem[64'h20] = wr_data;
    @(negedge clk);
    chk("abort_idle_mem_en", 64'(bus.mem_en), 64'd0);
    chk("abort_idle_l_ack", 64'(bus.l_ack), 64'd0);
    access(1'b1, 1'b0, 64'h20, 64'd0, lat_l, en_l, we_l, rd_l, er_l, st_l, so_l);
    chk("abort_readback_cycle", 64'(lat_l), 64'd1);
    chk("abort_readback", rd_l, wr_data);

    // Loader drops req during BUSY: one ack, no regrant
    @(posedge clk); #1;
    bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 64'h20;
    lq.push_back('{1'b0, 64'h20, 64'd0});
    @(posedge clk); #1;
    bus.l_req = 1'b0;
    @(negedge clk);
    chk("drop_l_ack", 64'(bus.l_ack), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("drop_no_reack", 64'(bus.l_ack), 64'd0);
      chk("drop_no_regrant", 64'(bus.mem_en), 64'd0);
    end

    // Randomized concurrent traffic from both requesters
    fork
      for (int k = 0; k < 40; k++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        access(1'b0, 1'($urandom_range(0, 1)), rand_addr(), {$urandom, $urandom},
               lat_p, en_p, we_p, rd_p, er_p, st_p, so_p);
        chk("rand_p_stall_profile", 64'(so_p), 64'd1);
      end
      for (int k = 0; k < 40; k++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        access(1'b1, 1'($urandom_range(0, 1)), rand_addr(), {$urandom, $urandom},
               lat_l, en_l, we_l, rd_l, er_l, st_l, so_l);
      end
    join

    repeat (4) @(negedge clk);
    chk("p_queue_drained", 64'(pq.size()), 64'd0);
    chk("l_queue_drained", 64'(lq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
